// File: rtl/q_writer_q16.sv
// Write-side front end of the packet-length queue feeding q_server_3_states.
// Sources push lengths in, a rising edge on go pops the head, and the head length is presented on a register.
module q_writer_q16 #(
    parameter int DEPTH_LOG2 = 4,
    parameter int LEN_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [LEN_W-1:0]      wr_len,
    input  logic                  go,
    output logic [LEN_W-1:0]      pkt_len,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  empty,
    output logic                  full,
    output logic [7:0]            drop_cnt,
    output logic                  underflow
);

    localparam int                DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [LEN_W-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2-1:0] wr_next;
    logic [DEPTH_LOG2-1:0] rd_next;
    logic [DEPTH_LOG2:0]   count_next;
    logic [LEN_W-1:0]      head_next;
    logic                  go_d;
    logic                  pop_edge;
    logic                  pop_ok;
    logic                  wr_ok;
    logic                  wr_bad;

    // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        pop_edge   = go & ~go_d;
        pop_ok     = pop_edge & ~empty;
        wr_ok      = wr_en & (wr_len != '0) & (~full | pop_ok);
        wr_bad     = wr_en & ~wr_ok;
        wr_next    = wr_ok  ? wr_ptr + 1'b1 : wr_ptr;
        rd_next    = pop_ok ? rd_ptr + 1'b1 : rd_ptr;
        count_next = count;
        if (wr_ok && !pop_ok)
            count_next = count + 1'b1;
        else if (!wr_ok && pop_ok)
            count_next = count - 1'b1;
        // The entry written this edge is not in mem yet, so forward it when it becomes the head.
        head_next = '0;
        if (count_next != '0)
            head_next = (wr_ok && (wr_ptr == rd_next)) ? wr_len : mem[rd_next];
    end

    // NOTE: all state updates use non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            empty     <= 1'b1;
            full      <= 1'b0;
            pkt_len   <= '0;
            drop_cnt  <= '0;
            underflow <= 1'b0;
            go_d      <= 1'b0;
        end else begin
            wr_ptr  <= wr_next;
            rd_ptr  <= rd_next;
            count   <= count_next;
            empty   <= (count_next == '0);
            full    <= (count_next == CNT_FULL);
            pkt_len <= head_next;
            go_d    <= go;
            if (wr_bad && (drop_cnt != 8'hFF))
                drop_cnt <= drop_cnt + 8'd1;
            if (pop_edge && empty)
                underflow <= 1'b1;
        end
    end

    // NOTE: storage has no reset; count and the pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (!rst && wr_ok)
            mem[wr_ptr] <= wr_len;
    end

endmodule
